bus_arbiter_mux: RTL

BUS_ARBITER_MUX -- requirements
Module: bus_arbiter_mux

---
 rtl/bus_arbiter_mux.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/bus_arbiter_mux.sv
// Round-robin bus arbiter driving a registered shared bus from NSRC sources.
// Owners are rotated out after MAXHOLD cycles when others wait, unless lock is held.
module bus_arbiter_mux #(
    parameter int WIDTH   = 16,
    parameter int NSRC    = 10,
    parameter int MAXHOLD = 4
) (
    input  logic                                       Clock,
    input  logic                                       Resetn,
    input  logic [NSRC-1:0]                            req,
    input  logic                                       lock,
    input  logic [NSRC*WIDTH-1:0]                      src_data,
    output logic [WIDTH-1:0]                           buswires,
    output logic [NSRC-1:0]                            grant,
    output logic [((NSRC > 1) ? $clog2(NSRC) : 1)-1:0] owner_id,
    output logic                                       bus_valid
);

    localparam int IDW = (NSRC > 1) ? $clog2(NSRC) : 1;
    localparam int HW  = (MAXHOLD > 1) ? $clog2(MAXHOLD + 1) : 1;
    localparam logic [HW-1:0]  MAXH     = HW'(MAXHOLD);
    localparam logic [IDW-1:0] LAST_IDX = IDW'(NSRC - 1);

    typedef enum logic {
        IDLE,
        OWNED
    } state_t;

    state_t           r_state;
    state_t           w_nextState;
    logic [IDW-1:0]   r_lastOwner;
    logic [IDW-1:0]   w_nextOwner;
    logic [HW-1:0]    r_hold;
    logic [HW-1:0]    w_nextHold;
    logic [HW-1:0]    w_holdInc;
    logic [NSRC-1:0]  r_grant;
    logic [IDW-1:0]   r_ownerId;
    logic             r_valid;
    logic [WIDTH-1:0] r_bus;
    logic [WIDTH-1:0] w_nextData;
    logic [NSRC-1:0]  w_ownerMask;
    logic             w_ownerReq;
    logic             w_othersReq;
    logic             w_found;
    logic [IDW-1:0]   w_winner;

    // Index 'offset' positions after 'base', wrapping at NSRC.
    function automatic logic [IDW-1:0] rrIndex(input logic [IDW-1:0] base, input int offset);
        int s;
        s = int'(base) + offset;
        if (s >= NSRC) begin
            s = s - NSRC;
        end
        return IDW'(s);
    endfunction

    assign w_ownerMask = NSRC'(1) << r_lastOwner;
    assign w_ownerReq  = |(req & w_ownerMask);
    assign w_othersReq = |(req & ~w_ownerMask);
    assign w_holdInc   = (r_hold >= MAXH) ? r_hold : r_hold + 1'b1;

    // Search starts just past the last owner, so the last owner has lowest priority.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int i = 1; i <= NSRC; i++) begin
            if (!w_found && req[rrIndex(r_lastOwner, i)]) begin
                w_found  = 1'b1;
                w_winner = rrIndex(r_lastOwner, i);
            end
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_nextOwner = r_lastOwner;
        w_nextHold  = r_hold;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_nextState = OWNED;
                    w_nextOwner = w_winner;
                    w_nextHold  = HW'(1);
                end
            end
            OWNED: begin
                if (!w_ownerReq) begin
                    if (w_found) begin
                        w_nextOwner = w_winner;
                        w_nextHold  = HW'(1);
                    end else begin
                        w_nextState = IDLE;
                        w_nextHold  = '0;
                    end
                end else if (w_othersReq && !lock && (r_hold >= MAXH)) begin
                    w_nextOwner = w_winner;
                    w_nextHold  = HW'(1);
                end else begin
                    w_nextHold  = w_holdInc;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Going idle leaves the bus holding its last driven value.
    always_comb begin
        w_nextData = r_bus;
        if (w_nextState == OWNED) begin
            for (int i = 0; i < NSRC; i++) begin
                if (IDW'(i) == w_nextOwner) begin
                    w_nextData = src_data[i*WIDTH +: WIDTH];
                end
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            r_state     <= IDLE;
            r_lastOwner <= LAST_IDX;
            r_hold      <= '0;
            r_grant     <= '0;
            r_ownerId   <= '0;
            r_valid     <= 1'b0;
            r_bus       <= '0;
        end else begin
            r_state     <= w_nextState;
            r_lastOwner <= w_nextOwner;
            r_hold      <= w_nextHold;
            r_valid     <= (w_nextState == OWNED);
            r_grant     <= (w_nextState == OWNED) ? (NSRC'(1) << w_nextOwner) : '0;
            r_ownerId   <= (w_nextState == OWNED) ? w_nextOwner : '0;
            r_bus       <= w_nextData;
        end
    end

    assign buswires  = r_bus;
    assign grant     = r_grant;
    assign owner_id  = r_ownerId;
    assign bus_valid = r_valid;

endmodule
